// File: rtl/buffer_unpacker.sv
// Unpacks 128-bit capture frames into a 16-bit word stream with one frame of
// double-buffering, a per-frame additive checksum and a completed-frame counter.
module buffer_unpacker #(
    parameter int unsigned WORDS = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDXW  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [WORDS*WIDTH-1:0] frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_index,
    output logic                   out_last,
    output logic [WIDTH-1:0]       checksum,
    output logic                   checksum_valid,
    output logic [15:0]            frame_count
);

    localparam int unsigned CNTW = 16;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    logic [WORDS-1:0][WIDTH-1:0] active_buf;
    logic [WORDS-1:0][WIDTH-1:0] pending_buf;
    logic                        active_full;
    logic                        pending_full;
    logic [IDXW-1:0]             index;
    logic [WIDTH-1:0]            acc;

    logic accept;
    logic word_hs;
    logic final_hs;
    logic load_active;
    logic load_pending;

    // Handshake decode; a new frame bypasses pending when active frees up this cycle.
    always_comb begin
        frame_ready  = !pending_full && !reset;
        accept       = frame_valid && frame_ready;
        word_hs      = active_full && out_ready;
        final_hs     = word_hs && (index == LAST_IDX);
        load_active  = accept && (!active_full || (final_hs && !pending_full));
        load_pending = accept && !load_active;
    end

    assign out_valid = active_full;
    assign out_data  = active_buf[index];
    assign out_index = index;
    assign out_last  = (index == LAST_IDX);

    // Active/pending storage and word index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_buf   <= '0;
            pending_buf  <= '0;
            active_full  <= 1'b0;
            pending_full <= 1'b0;
            index        <= '0;
        end else begin
            if (load_active) begin
                active_buf  <= frame;
                active_full <= 1'b1;
                index       <= '0;
            end else if (final_hs) begin
                index <= '0;
                if (pending_full) begin
                    active_buf   <= pending_buf;
                    pending_full <= 1'b0;
                end else begin
                    active_full <= 1'b0;
                end
            end else if (word_hs) begin
                index <= index + IDXW'(1);
            end
            if (load_pending) begin
                pending_buf  <= frame;
                pending_full <= 1'b1;
            end
        end
    end

    // Checksum accumulator, capture register and completed-frame counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            checksum       <= '0;
            checksum_valid <= 1'b0;
            frame_count    <= '0;
        end else begin
            checksum_valid <= final_hs;
            if (final_hs) begin
                checksum    <= acc + out_data;
                acc         <= '0;
                frame_count <= frame_count + CNTW'(1);
            end else if (word_hs) begin
                acc <= acc + out_data;
            end
        end
    end

endmodule

// File: tb/tb_buffer_unpacker.sv
// Directed bench for buffer_unpacker: frames are queued into a word/checksum
// scoreboard at acceptance and checked by a negedge monitor as they stream out.
module tb_buffer_unpacker;

    localparam int unsigned WORDS = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned FW    = WORDS * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDXW-1:0]  index;
        logic             last;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_valid;
    logic              frame_ready;
    logic [FW-1:0]     frame;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [IDXW-1:0]   out_index;
    logic              out_last;
    logic [WIDTH-1:0]  checksum;
    logic              checksum_valid;
    logic [15:0]       frame_count;

    int checks = 0;
    int errors = 0;
    exp_t             sb[$];
    logic [WIDTH-1:0] ck_q[$];
    int               exp_frames = 0;

    buffer_unpacker #(.WORDS(WORDS), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clock(clock), .reset(reset),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame(frame),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .checksum(checksum), .checksum_valid(checksum_valid), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [FW-1:0] mkf(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] step);
        logic [FW-1:0] f;
        for (int k = 0; k < int'(WORDS); k++)
            f[k*WIDTH +: WIDTH] = base + WIDTH'(k) * step;
        return f;
    endfunction

    // Offer a frame, wait for acceptance, then record its expected words and checksum.
    task automatic send_frame(input logic [FW-1:0] f, output int waited);
        logic [WIDTH-1:0] sum;
        exp_t e;
        frame       = f;
        frame_valid = 1'b1;
        waited      = 0;
        while (!frame_ready && waited < 200) begin
            tick;
            waited++;
        end
        chk("accept_timeout", 32'(waited < 200), 32'd1);
        tick;
        frame_valid = 1'b0;
        sum = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            e.data  = f[k*WIDTH +: WIDTH];
            e.index = IDXW'(k);
            e.last  = (k == int'(WORDS) - 1);
            sb.push_back(e);
            sum = sum + e.data;
        end
        ck_q.push_back(sum);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((out_valid || sb.size() > 0) && n < 500) begin
            tick;
            n++;
        end
        chk("drain_timeout", 32'(n < 500), 32'd1);
        tick;
    endtask

    // Output monitor: scoreboard compare, no-bubble, stall stability, checksum pulse.
    logic             cv_due = 1'b0;
    logic [WIDTH-1:0] cv_sum = '0;
    logic             stalled = 1'b0;
    logic [WIDTH-1:0] held_data = '0;
    logic [IDXW-1:0]  held_index = '0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            cv_due  = 1'b0;
            stalled = 1'b0;
        end else begin
            chk("checksum_valid", 32'(checksum_valid), 32'(cv_due));
            if (cv_due) begin
                chk("checksum", 32'(checksum), 32'(cv_sum));
                chk("frame_count", 32'(frame_count), 32'(exp_frames));
            end
            cv_due = 1'b0;
            if (stalled) begin
                chk("stall_data", 32'(out_data), 32'(held_data));
                chk("stall_index", 32'(out_index), 32'(held_index));
            end
            if (sb.size() > 0)
                chk("no_bubble", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_index", 32'(out_index), 32'(e.index));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) begin
                        cv_due = 1'b1;
                        cv_sum = ck_q.pop_front();
                        exp_frames++;
                    end
                end
            end
            stalled    = out_valid && !out_ready;
            held_data  = out_data;
            held_index = out_index;
        end
    end

    initial begin
        int w;
        logic [FW-1:0] rf;
        reset       = 1'b1;
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        frame       = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_checksum_valid", 32'(checksum_valid), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(frame_ready), 32'd1);

        // Single frame, word k = k+1.
        out_ready = 1'b1;
        send_frame(mkf(16'h0001, 16'h0001), w);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_word0", 32'(out_data), 32'h0001);
        wait_idle;
        chk("t1_checksum", 32'(checksum), 32'h0024);
        chk("t1_frame_count", 32'(frame_count), 32'd1);

        // Back-to-back frames; ready low exactly while the second is pending.
        send_frame(mkf(16'h1000, 16'h0001), w);
        send_frame(mkf(16'h2000, 16'h0003), w);
        w = 0;
        while (!frame_ready && w < 50) begin
            w++;
            tick;
        end
        chk("pending_ready_low_cycles", 32'(w), 32'd7);
        wait_idle;
        chk("t2_frame_count", 32'(frame_count), 32'd3);

        // Backpressure pattern 1,0,0,1,0,0...
        for (int k = 0; k < int'(WORDS); k++)
            rf[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        send_frame(rf, w);
        for (int i = 0; i < 60 && (out_valid || sb.size() > 0); i++) begin
            out_ready = (i % 3 == 0);
            tick;
        end
        chk("stall_drained", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        wait_idle;

        // Checksum wrap.
        send_frame(mkf(16'hFFFF, 16'h0000), w);
        wait_idle;
        chk("wrap_checksum", 32'(checksum), 32'hFFF8);
        chk("wrap_frame_count", 32'(frame_count), 32'(exp_frames));

        // Third frame blocked while active and pending are both full.
        out_ready = 1'b0;
        send_frame(mkf(16'hA000, 16'h0011), w);
        send_frame(mkf(16'hB000, 16'h0101), w);
        chk("full_ready_low", 32'(frame_ready), 32'd0);
        repeat (3) tick;
        chk("full_ready_still_low", 32'(frame_ready), 32'd0);
        chk("full_index_held", 32'(out_index), 32'd0);
        out_ready = 1'b1;
        send_frame(mkf(16'hC000, 16'h0007), w);
        chk("third_wait_cycles", 32'(w), 32'd8);
        wait_idle;

        // Reset at word 3 with a frame pending.
        send_frame(mkf(16'h5000, 16'h0001), w);
        send_frame(mkf(16'h6000, 16'h0001), w);
        repeat (2) tick;
        chk("pre_reset_index", 32'(out_index), 32'd3);
        reset = 1'b1;
        #1;
        sb.delete();
        ck_q.delete();
        exp_frames = 0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
        chk("mid_rst_checksum", 32'(checksum), 32'd0);
        chk("mid_rst_out_index", 32'(out_index), 32'd0);
        chk("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
        repeat (2) tick;
        reset = 1'b0;
        #1;
        send_frame(mkf(16'h7000, 16'h0002), w);
        chk("post_reset_index", 32'(out_index), 32'd0);
        chk("post_reset_word0", 32'(out_data), 32'h7000);
        wait_idle;
        chk("post_reset_frame_count", 32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
